// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle carrying the AW, W, B, AR and R channels.
// The master modport is the initiator view and the slave modport is the target view.
interface axi4_lite_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: turns a command/response stream into one
// read or write transaction at a time, with a response timeout against dead slaves.
module axil_cmd_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_wdata,
  input  logic [DW/8-1:0] cmd_wstrb,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic [1:0]      rsp_resp,
  output logic            rsp_timeout,
  axi4_lite_if.master     m
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_RESP, RSP} state_e;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            arvalid_q, arvalid_d;
  logic            bready_q, bready_d;
  logic            rready_q, rready_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      resp_q, resp_d;
  logic            tmo_q, tmo_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          cnt_d   = CW'(TIMEOUT);
          tmo_d   = 1'b0;
          if (cmd_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD;
          end
        end
      end
      WR: begin
        // AW and W retire independently; B is only requested once both are gone.
        awvalid_d = awvalid_q && !m.awready;
        wvalid_d  = wvalid_q && !m.wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m.bvalid && bready_q) begin
          resp_d   = m.bresp;
          rdata_d  = '0;
          bready_d = 1'b0;
          state_d  = RSP;
        end
      end
      RD: begin
        if (m.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m.rvalid && rready_q) begin
          rdata_d  = m.rdata;
          resp_d   = m.rresp;
          rready_d = 1'b0;
          state_d  = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A response captured in the expiry cycle already moved us to RSP and wins.
    if (TIMEOUT != 0 &&
        (state_q == WR || state_q == WR_RESP || state_q == RD || state_q == RD_RESP)) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1) && state_d != RSP) begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
        bready_d  = 1'b0;
        rready_d  = 1'b0;
        rdata_d   = '0;
        resp_d    = 2'b10;
        tmo_d     = 1'b1;
        state_d   = RSP;
      end
    end

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= '0;
      tmo_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      tmo_q       <= tmo_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = (state_q == RSP);
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign rsp_timeout = tmo_q;

  assign m.awaddr  = addr_q;
  assign m.awprot  = 3'b000;
  assign m.awvalid = awvalid_q;
  assign m.wdata   = wdata_q;
  assign m.wstrb   = wstrb_q;
  assign m.wvalid  = wvalid_q;
  assign m.bready  = bready_q;
  assign m.araddr  = addr_q;
  assign m.arprot  = 3'b000;
  assign m.arvalid = arvalid_q;
  assign m.rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: the slave side of the bus is driven by hand
// from each scenario task, with expected values written out per cycle.
module tb_axil_cmd_master;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;

  int vectors = 0;
  int miscompares = 0;

  axi4_lite_if #(.DW(32), .AW(32)) axi ();

  axil_cmd_master #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_we      (cmd_we),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_resp    (rsp_resp),
    .rsp_timeout (rsp_timeout),
    .m           (axi)
  );

  always #5 aclk = ~aclk;

  // Advance one rising edge and settle just past it.
  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb);
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wstrb = strb;
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_rsp;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    tick;
    tick;
    vectors++;
    if ({cmd_ready, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_handshakes: got %b want 0000000",
               {cmd_ready, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid});
    end
    vectors++;
    if ({rsp_rdata, rsp_resp, rsp_timeout} !== 35'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_rsp: got rdata=%h resp=%b tmo=%b want all 0", rsp_rdata, rsp_resp, rsp_timeout);
    end
    aresetn = 1'b1;
    tick;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_release_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_read_delayed;
    axi.arready = 1'b0;
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({axi.arvalid, axi.araddr, cmd_ready} !== {1'b1, 32'h20, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL rd_ar_hold[%0d]: got arvalid=%b araddr=%h cmd_ready=%b want 1 00000020 0",
                 i, axi.arvalid, axi.araddr, cmd_ready);
      end
      if (i < 3) tick;
    end
    axi.arready = 1'b1;
    tick;
    axi.arready = 1'b0;
    vectors++;
    if ({axi.arvalid, axi.rready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL rd_ar_done: got arvalid,rready=%b want 01", {axi.arvalid, axi.rready});
    end
    tick;
    vectors++;
    if ({rsp_valid, axi.rready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL rd_wait_r: got rsp_valid,rready=%b want 01", {rsp_valid, axi.rready});
    end
    axi.rvalid = 1'b1;
    axi.rdata  = 32'h12345678;
    axi.rresp  = 2'b00;
    tick;
    axi.rvalid = 1'b0;
    axi.rdata  = 32'h0;
    // Response held under backpressure for 5 cycles before it is consumed.
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if ({rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, cmd_ready, axi.rready} !==
          {1'b1, 32'h12345678, 2'b00, 1'b0, 1'b0, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL rd_rsp_hold[%0d]: got valid=%b rdata=%h resp=%b tmo=%b cmd_ready=%b rready=%b want 1 12345678 00 0 0 0",
                 i, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, cmd_ready, axi.rready);
      end
      if (i < 5) tick;
    end
    finish_rsp;
    vectors++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL rd_rsp_release: got rsp_valid,cmd_ready=%b want 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_write_zero_wait;
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    vectors++;
    if ({axi.awvalid, axi.wvalid, axi.awaddr, axi.wdata, axi.wstrb, cmd_ready} !==
        {1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL wr_issue: got aw=%b w=%b addr=%h data=%h strb=%h cmd_ready=%b want 1 1 00000010 deadbeef f 0",
               axi.awvalid, axi.wvalid, axi.awaddr, axi.wdata, axi.wstrb, cmd_ready);
    end
    tick;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    vectors++;
    if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL wr_bready: got aw,w,bready=%b want 001", {axi.awvalid, axi.wvalid, axi.bready});
    end
    axi.bvalid = 1'b1;
    axi.bresp  = 2'b00;
    tick;
    axi.bvalid = 1'b0;
    vectors++;
    if ({rsp_valid, rsp_resp, rsp_timeout, rsp_rdata, axi.bready} !== {1'b1, 2'b00, 1'b0, 32'h0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL wr_rsp: got valid=%b resp=%b tmo=%b rdata=%h bready=%b want 1 00 0 00000000 0",
               rsp_valid, rsp_resp, rsp_timeout, rsp_rdata, axi.bready);
    end
    finish_rsp;
  endtask

  task automatic test_skewed(input bit w_first);
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    issue(1'b1, 32'h30, 32'hA5A55A5A, 4'b0011);
    if (w_first) axi.wready = 1'b1;
    else         axi.awready = 1'b1;
    tick;
    axi.wready  = 1'b0;
    axi.awready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({axi.awvalid, axi.wvalid, axi.bready} !== (w_first ? 3'b100 : 3'b010)) begin
        miscompares++;
        $display("[TB] FAIL skew_first[%0d] w_first=%0d: got aw,w,bready=%b want %b",
                 i, w_first, {axi.awvalid, axi.wvalid, axi.bready}, (w_first ? 3'b100 : 3'b010));
      end
      vectors++;
      if ({axi.awaddr, axi.wdata, axi.wstrb} !== {32'h30, 32'hA5A55A5A, 4'b0011}) begin
        miscompares++;
        $display("[TB] FAIL skew_stable[%0d]: got addr=%h data=%h strb=%h want 00000030 a5a55a5a 3",
                 i, axi.awaddr, axi.wdata, axi.wstrb);
      end
      if (i == 0) tick;
    end
    if (w_first) axi.awready = 1'b1;
    else         axi.wready  = 1'b1;
    tick;
    axi.wready  = 1'b0;
    axi.awready = 1'b0;
    vectors++;
    if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL skew_both w_first=%0d: got aw,w,bready=%b want 001", w_first,
               {axi.awvalid, axi.wvalid, axi.bready});
    end
    axi.bvalid = 1'b1;
    axi.bresp  = 2'b01;
    tick;
    vectors++;
    if ({rsp_valid, rsp_resp, axi.bready} !== {1'b1, 2'b01, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL skew_b w_first=%0d: got valid=%b resp=%b bready=%b want 1 01 0",
               w_first, rsp_valid, rsp_resp, axi.bready);
    end
    tick;
    axi.bvalid = 1'b0;
    vectors++;
    if ({rsp_valid, rsp_resp, axi.bready} !== {1'b1, 2'b01, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL skew_single_b w_first=%0d: got valid=%b resp=%b bready=%b want 1 01 0",
               w_first, rsp_valid, rsp_resp, axi.bready);
    end
    finish_rsp;
  endtask

  task automatic test_timeout;
    int early;
    early = 0;
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    issue(1'b1, 32'h50, 32'h0BADF00D, 4'hF);
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick;
      if (rsp_valid) early++;
    end
    vectors++;
    if (early !== 0) begin
      miscompares++;
      $display("[TB] FAIL tmo_early: got %0d cycles with rsp_valid before edge 16 want 0", early);
    end
    tick;
    vectors++;
    if ({rsp_valid, rsp_resp, rsp_timeout, rsp_rdata, axi.bready, axi.awvalid, axi.wvalid} !==
        {1'b1, 2'b10, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL tmo_fire: got valid=%b resp=%b tmo=%b rdata=%h bready=%b want 1 10 1 00000000 0",
               rsp_valid, rsp_resp, rsp_timeout, rsp_rdata, axi.bready);
    end
    finish_rsp;
    vectors++;
    if ({axi.bready, rsp_timeout, cmd_ready} !== 3'b011) begin
      miscompares++;
      $display("[TB] FAIL tmo_after: got bready,tmo,cmd_ready=%b want 011", {axi.bready, rsp_timeout, cmd_ready});
    end
  endtask

  task automatic test_slave_error;
    axi.arready = 1'b1;
    issue(1'b0, 32'h40, 32'h0, 4'h0);
    vectors++;
    if ({rsp_timeout, axi.arvalid} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL err_tmo_clear: got tmo,arvalid=%b want 01", {rsp_timeout, axi.arvalid});
    end
    tick;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b1;
    axi.rdata   = 32'hBAD0BAD0;
    axi.rresp   = 2'b10;
    tick;
    axi.rvalid  = 1'b0;
    vectors++;
    if ({rsp_valid, rsp_resp, rsp_timeout, rsp_rdata} !== {1'b1, 2'b10, 1'b0, 32'hBAD0BAD0}) begin
      miscompares++;
      $display("[TB] FAIL err_rsp: got valid=%b resp=%b tmo=%b rdata=%h want 1 10 0 bad0bad0",
               rsp_valid, rsp_resp, rsp_timeout, rsp_rdata);
    end
    finish_rsp;
    axi.arready = 1'b1;
    issue(1'b0, 32'h44, 32'h0, 4'h0);
    vectors++;
    if ({axi.arvalid, axi.araddr} !== {1'b1, 32'h44}) begin
      miscompares++;
      $display("[TB] FAIL err_next_accept: got arvalid=%b araddr=%h want 1 00000044", axi.arvalid, axi.araddr);
    end
    tick;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b1;
    axi.rdata   = 32'h00000055;
    axi.rresp   = 2'b00;
    tick;
    axi.rvalid  = 1'b0;
    vectors++;
    if ({rsp_valid, rsp_resp, rsp_rdata} !== {1'b1, 2'b00, 32'h55}) begin
      miscompares++;
      $display("[TB] FAIL err_next_rsp: got valid=%b resp=%b rdata=%h want 1 00 00000055", rsp_valid, rsp_resp, rsp_rdata);
    end
    finish_rsp;
  endtask

  task automatic test_reset_mid_write;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    issue(1'b1, 32'h60, 32'h11112222, 4'hF);
    vectors++;
    if ({axi.awvalid, axi.wvalid} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_issue: got aw,w=%b want 11", {axi.awvalid, axi.wvalid});
    end
    aresetn = 1'b0;
    tick;
    axi.bvalid = 1'b1;
    axi.bresp  = 2'b00;
    vectors++;
    if ({cmd_ready, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid} !== 7'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_valids: got %b want 0000000",
               {cmd_ready, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid});
    end
    tick;
    aresetn = 1'b1;
    tick;
    vectors++;
    if ({cmd_ready, rsp_valid, axi.bready} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_release: got cmd_ready,rsp_valid,bready=%b want 100", {cmd_ready, rsp_valid, axi.bready});
    end
    tick;
    axi.bvalid = 1'b0;
    vectors++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL rst_stale_b: got cmd_ready,rsp_valid=%b want 10", {cmd_ready, rsp_valid});
    end
  endtask

  initial begin
    aresetn     = 1'b0;
    cmd_valid   = 1'b0;
    cmd_we      = 1'b0;
    cmd_addr    = 32'h0;
    cmd_wdata   = 32'h0;
    cmd_wstrb   = 4'h0;
    rsp_ready   = 1'b0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = 32'h0;
    axi.rresp   = 2'b00;

    test_reset;
    test_read_delayed;
    test_write_zero_wait;
    test_skewed(1'b1);
    test_skewed(1'b0);
    test_timeout;
    test_slave_error;
    test_reset_mid_write;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- Single-outstanding AXI4-Lite initiator: converts a simple command/response stream into AXI4-Lite read and write transactions on an axi4_lite_if master port.
- It is the initiator counterpart of the mmr crossbar slaves (mem_controller, qspi register block). Internal engines (e.g. a flash-boot loader or a self-test sequencer) use it to reach the crossbar or the PS GP/HP ports without hand-writing AXI handshakes.
- Includes a response timeout so that a hung slave cannot lock up the requester.

Parameters:
- AW, 32: address width; sets cmd_addr and the interface address width.
- DW, 32: data width; sets cmd_wdata/rsp_rdata and the interface data width. Must be 32 or 64.
- TIMEOUT, 1024: cycles allowed from issue of a transaction to its B/R response. 0 disables the timeout.

Ports:
- aclk  in  1  clock; all logic is in this single domain.
- aresetn  in  1  synchronous active-low reset, sampled on the rising edge of aclk.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high on a clock edge.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  AW  byte address; driven unmodified onto awaddr/araddr.
- cmd_wdata  in  DW  write data.
- cmd_wstrb  in  DW/8  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
- rsp_rdata  out  DW  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP from the slave; 2'b10 on timeout.
- rsp_timeout  out  1  set when the transaction was aborted by the timeout.
- m  master  axi4_lite_if #(DW,AW)  AXI4-Lite bus. Uses channels AW, W, B, AR and R. awprot and arprot are tied to 0.

Behaviour:
- Reset values (aresetn low): all valid and ready outputs 0 (cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid); rsp_rdata, rsp_resp and rsp_timeout 0; state IDLE; timeout counter 0.
- Reset applied mid-transaction: the block returns to IDLE on the next edge and all valids drop. Any pending slave response after reset is ignored.
- FSM states: IDLE, WR, WR_RESP, RD, RD_RESP, RSP.
- IDLE: cmd_ready=1.
  - On an accepted command, latch the command fields and load the timeout counter.
  - Write command: next state WR; awvalid and wvalid go high together on the next cycle.
  - Read command: next state RD; arvalid goes high on the next cycle.
- WR: awvalid and wvalid are tracked independently.
  - Each valid drops on the cycle after its own ready handshake.
  - AW and W may be accepted in either order or in the same cycle.
  - When both are accepted, go to WR_RESP with bready=1 in that cycle.
- WR_RESP: on bvalid&&bready, capture bresp, set rsp_rdata=0, drop bready, go to RSP.
- RD: when arready is seen, arvalid drops and the FSM goes to RD_RESP with rready=1.
- RD_RESP: on rvalid&&rready, capture rdata and rresp, drop rready, go to RSP.
- RSP: rsp_valid=1 with stable outputs until rsp_ready; then return to IDLE.
  - cmd_ready is 0 outside IDLE, so only one transaction is outstanding.
  - Minimum command-to-command period is 4 cycles for a zero-wait slave.
- Latency, zero-wait slave:
  - Command accepted at edge 0.
  - AW/W (or AR) handshake at edge 1.
  - B/R handshake at edge 2.
  - rsp_valid high in the cycle after edge 2.
- Timeout:
  - The counter decrements every cycle in WR, WR_RESP, RD and RD_RESP.
  - On reaching 0 (TIMEOUT != 0), all AXI valids and readies drop, rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0, and the FSM goes to RSP.
  - Dropping an unaccepted valid is an intentional recovery violation for a dead slave.
  - A slave response that arrives in the same cycle the counter expires wins: it is captured normally and rsp_timeout stays 0.
- Write data and strobes are held constant from issue until W is accepted; the address is held until AW (or AR) is accepted.
- rsp_timeout clears when the next command is accepted.

Test Plan:
- Write, zero-wait slave. Command we=1, addr=0x10, wdata=0xDEADBEEF, wstrb=0xF → one AW and one W handshake at edge 1, bready at edge 2, rsp_valid in the following cycle with rsp_resp=0, rsp_timeout=0.
- Read with delayed handshakes. Read of addr=0x20; the slave holds arready low 3 cycles and then returns rdata=0x12345678 with rresp=0 two cycles later → arvalid stays high and stable until accepted; response rdata=0x12345678, resp=0.
- Skewed AW/W acceptance. Write where W is accepted 2 cycles before AW (then repeat with the order swapped) → each valid drops only after its own handshake; bready does not assert until both are accepted; exactly one B is consumed.
- Timeout. TIMEOUT=16; the slave never asserts bvalid → rsp_valid with rsp_resp=2'b10, rsp_timeout=1 exactly 16 cycles after issue; bready is 0 afterwards.
- Backpressure and reset. Hold rsp_ready=0 for 5 cycles → rsp_* stay stable and cmd_ready stays 0. Assert aresetn=0 mid-WR → the next edge shows all valids 0 and cmd_ready=0 while in reset; cmd_ready=1 in the first cycle after reset is released.
- Slave error. Read returning rresp=2'b10 → rsp_resp=2'b10 with rsp_timeout=0, and the next command is accepted normally.
